// File: rtl/bcrypt_proxy_arbiter_if.sv
// Signal bundle between bcrypt_data, the proxy arbiter, its proxies and the result consumer.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface bcrypt_proxy_arbiter_if #(
    parameter int NUM_PROXIES = 4
);
    logic [7:0]             din;
    logic [1:0]             ctrl;
    logic                   wr_en;
    logic                   crypt_ready;
    logic                   init_ready;
    logic                   err_no_target;
    logic [7:0]             px_din;
    logic [1:0]             px_ctrl;
    logic [NUM_PROXIES-1:0] px_wr_en;
    logic [NUM_PROXIES-1:0] px_init_ready;
    logic [NUM_PROXIES-1:0] px_crypt_ready;
    logic [NUM_PROXIES-1:0] px_rd_en;
    logic [NUM_PROXIES-1:0] px_empty;
    logic [NUM_PROXIES-1:0] px_dout;
    logic [7:0]             out_data;
    logic [3:0]             out_proxy;
    logic                   out_valid;
    logic                   out_ready;

    modport slave (
        input  din, ctrl, wr_en, px_init_ready, px_crypt_ready, px_empty, px_dout, out_ready,
        output crypt_ready, init_ready, err_no_target, px_din, px_ctrl, px_wr_en, px_rd_en,
               out_data, out_proxy, out_valid
    );

    modport master (
        output din, ctrl, wr_en, px_init_ready, px_crypt_ready, px_empty, px_dout, out_ready,
        input  crypt_ready, init_ready, err_no_target, px_din, px_ctrl, px_wr_en, px_rd_en,
               out_data, out_proxy, out_valid
    );
endinterface

// File: rtl/bcrypt_proxy_arbiter.sv
// Steers bcrypt_data packets to proxies (round-robin data, broadcast init) and
// collects serial results from proxies round-robin into an upstream byte stream.
module bcrypt_proxy_arbiter #(
    parameter int         NUM_PROXIES     = 4,
    parameter int         RESULT_BITS     = 64,
    parameter int         RD_LATENCY      = 3,
    parameter logic [1:0] CTRL_DATA_START = 2'd1,
    parameter logic [1:0] CTRL_INIT_START = 2'd2,
    parameter logic [1:0] CTRL_END        = 2'd3
) (
    input logic                   CLK,
    input logic                   rst,
    bcrypt_proxy_arbiter_if.slave bus
);
    localparam int unsigned NP        = NUM_PROXIES;
    localparam int          PW        = (NUM_PROXIES > 1) ? $clog2(NUM_PROXIES) : 1;
    localparam int          NBYTES    = RESULT_BITS / 8;
    localparam int          BW        = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int          CW        = $clog2(RESULT_BITS + RD_LATENCY);
    localparam int          WAIT_LAST = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p, input int unsigned k);
        int unsigned s;
        s = p + k;
        if (s >= NP) s = s - NP;
        return PW'(s);
    endfunction

    // ---------------- input side ----------------
    typedef enum logic [1:0] {IN_IDLE, IN_BODY, IN_FLUSH, IN_DROP} in_state_t;

    in_state_t              in_state, in_next;
    logic [NUM_PROXIES-1:0] target_mask, target_next, byte_mask;
    logic [PW-1:0]          wr_ptr, wr_ptr_next;
    logic                   err_set;
    logic                   rr_found;
    logic [PW-1:0]          rr_sel;
    logic [NUM_PROXIES-1:0] rr_mask;

    logic                   crypt_ready_r, init_ready_r, err_r;
    logic [7:0]             px_din_r;
    logic [1:0]             px_ctrl_r;
    logic [NUM_PROXIES-1:0] px_wr_en_r;

    // First crypt-ready proxy at or after wr_ptr, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_sel   = '0;
        for (int unsigned k = 0; k < NP; k++) begin
            if (!rr_found && bus.px_crypt_ready[wrap_inc(wr_ptr, k)]) begin
                rr_found = 1'b1;
                rr_sel   = wrap_inc(wr_ptr, k);
            end
        end
        rr_mask         = '0;
        rr_mask[rr_sel] = rr_found;
    end

    always_comb begin
        in_next     = in_state;
        target_next = target_mask;
        byte_mask   = '0;
        wr_ptr_next = wr_ptr;
        err_set     = 1'b0;
        case (in_state)
            IN_IDLE: begin
                if (bus.wr_en && bus.ctrl == CTRL_DATA_START) begin
                    byte_mask   = rr_mask;
                    target_next = rr_mask;
                    if (rr_found) begin
                        wr_ptr_next = wrap_inc(rr_sel, 1);
                        in_next     = IN_BODY;
                    end else begin
                        err_set = 1'b1;
                        in_next = IN_DROP;
                    end
                end else if (bus.wr_en && bus.ctrl == CTRL_INIT_START) begin
                    byte_mask   = bus.px_init_ready;
                    target_next = bus.px_init_ready;
                    if (|bus.px_init_ready) begin
                        in_next = IN_BODY;
                    end else begin
                        err_set = 1'b1;
                        in_next = IN_DROP;
                    end
                end
            end
            IN_BODY: begin
                byte_mask = target_mask;
                if (bus.wr_en && bus.ctrl == CTRL_END) in_next = IN_FLUSH;
            end
            IN_FLUSH: begin
                target_next = '0;
                in_next     = IN_IDLE;
            end
            IN_DROP: begin
                if (bus.wr_en && bus.ctrl == CTRL_END) in_next = IN_IDLE;
            end
            default: in_next = IN_IDLE;
        endcase
    end

    // Ready flags look at the next state so they read 0 in every non-IDLE cycle.
    always_ff @(posedge CLK) begin
        if (rst) begin
            in_state      <= IN_IDLE;
            target_mask   <= '0;
            wr_ptr        <= '0;
            err_r         <= 1'b0;
            crypt_ready_r <= 1'b0;
            init_ready_r  <= 1'b0;
            px_din_r      <= '0;
            px_ctrl_r     <= '0;
            px_wr_en_r    <= '0;
        end else begin
            in_state      <= in_next;
            target_mask   <= target_next;
            wr_ptr        <= wr_ptr_next;
            err_r         <= err_r | err_set;
            crypt_ready_r <= (|bus.px_crypt_ready) && (in_next == IN_IDLE);
            init_ready_r  <= (|bus.px_init_ready) && (in_next == IN_IDLE);
            px_din_r      <= bus.din;
            px_ctrl_r     <= bus.ctrl;
            px_wr_en_r    <= bus.wr_en ? byte_mask : '0;
        end
    end

    assign bus.crypt_ready   = crypt_ready_r;
    assign bus.init_ready    = init_ready_r;
    assign bus.err_no_target = err_r;
    assign bus.px_din        = px_din_r;
    assign bus.px_ctrl       = px_ctrl_r;
    assign bus.px_wr_en      = px_wr_en_r;

    // ---------------- output side ----------------
    typedef enum logic [1:0] {OUT_SCAN, OUT_WAIT, OUT_SHIFT, OUT_EMIT} out_state_t;

    out_state_t             out_state, out_next;
    logic [PW-1:0]          rd_ptr, rd_ptr_next, cur, cur_next;
    logic [CW-1:0]          cnt, cnt_next;
    logic [BW-1:0]          byte_cnt, byte_cnt_next;
    logic [RESULT_BITS-1:0] shreg, shreg_next;
    logic [NUM_PROXIES-1:0] rd_en_c;

    always_comb begin
        out_next      = out_state;
        rd_ptr_next   = rd_ptr;
        cur_next      = cur;
        cnt_next      = cnt;
        byte_cnt_next = byte_cnt;
        shreg_next    = shreg;
        rd_en_c       = '0;
        case (out_state)
            OUT_SCAN: begin
                if (!bus.px_empty[rd_ptr]) begin
                    cur_next        = rd_ptr;
                    rd_en_c[rd_ptr] = 1'b1;
                    cnt_next        = '0;
                    out_next        = (RD_LATENCY > 1) ? OUT_WAIT : OUT_SHIFT;
                end else begin
                    rd_ptr_next = wrap_inc(rd_ptr, 1);
                end
            end
            OUT_WAIT: begin
                if (cnt == CW'(WAIT_LAST)) begin
                    cnt_next = '0;
                    out_next = OUT_SHIFT;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            OUT_SHIFT: begin
                shreg_next = {shreg[RESULT_BITS-2:0], bus.px_dout[cur]};
                if (cnt == CW'(RESULT_BITS - 1)) begin
                    out_next      = OUT_EMIT;
                    byte_cnt_next = '0;
                    rd_ptr_next   = wrap_inc(cur, 1);
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            OUT_EMIT: begin
                // The top byte of shreg is always the one on offer; shift on accept.
                if (bus.out_ready) begin
                    shreg_next = shreg << 8;
                    if (byte_cnt == BW'(NBYTES - 1)) out_next = OUT_SCAN;
                    else byte_cnt_next = byte_cnt + 1'b1;
                end
            end
            default: out_next = OUT_SCAN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            out_state <= OUT_SCAN;
            rd_ptr    <= '0;
            cur       <= '0;
            cnt       <= '0;
            byte_cnt  <= '0;
            shreg     <= '0;
        end else begin
            out_state <= out_next;
            rd_ptr    <= rd_ptr_next;
            cur       <= cur_next;
            cnt       <= cnt_next;
            byte_cnt  <= byte_cnt_next;
            shreg     <= shreg_next;
        end
    end

    assign bus.px_rd_en  = rst ? '0 : rd_en_c;
    assign bus.out_valid = (out_state == OUT_EMIT);
    assign bus.out_data  = shreg[RESULT_BITS-1 -: 8];
    assign bus.out_proxy = 4'(cur);
endmodule

// File: doc/bcrypt_proxy_arbiter.md
Name: bcrypt_proxy_arbiter

Overview:
Sits between bcrypt_data and NUM_PROXIES bcrypt_proxy instances.
- Input side: steers each 8-bit data packet to one proxy that reports crypt_ready, chosen round-robin. Broadcasts initialization packets to every proxy that reports init_ready.
- Output side: polls proxies round-robin for finished results. Reads one result as a serial bitstream, deserializes it, and presents it upstream as a byte stream with a valid/ready handshake.

Parameters:
- NUM_PROXIES, 4, number of attached proxies (2..16).
- RESULT_BITS, 64, length of one serial result from a proxy; must be a multiple of 8.
- RD_LATENCY, 3, cycles from a proxy rd_en pulse to the first result bit on that proxy's dout.

Ports:
- CLK  in  1  clock.
- rst  in  1  reset.
- din  in  8  packet byte from bcrypt_data.
- ctrl  in  2  packet control; codes `CTRL_DATA_START, `CTRL_INIT_START, `CTRL_END from bcrypt.vh; any other value is a body byte.
- wr_en  in  1  din/ctrl valid this cycle.
- crypt_ready  out  1  a data packet may be started.
- init_ready  out  1  an init packet may be started.
- err_no_target  out  1  sticky: a packet was started with no eligible proxy.
- px_din  out  8  broadcast byte bus to all proxies.
- px_ctrl  out  2  broadcast ctrl bus to all proxies.
- px_wr_en  out  NUM_PROXIES  per-proxy write enable.
- px_init_ready  in  NUM_PROXIES  per-proxy init_ready.
- px_crypt_ready  in  NUM_PROXIES  per-proxy crypt_ready.
- px_rd_en  out  NUM_PROXIES  per-proxy read request pulse.
- px_empty  in  NUM_PROXIES  per-proxy empty.
- px_dout  in  NUM_PROXIES  per-proxy serial result bit.
- out_data  out  8  result byte.
- out_proxy  out  4  index of the proxy the current result came from.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data this cycle.

Behaviour:
- Reset: rst, synchronous, active-high; clock CLK. Effects:
  - All outputs go to 0, including err_no_target.
  - Both FSMs return to IDLE/SCAN; both round-robin pointers go to 0; the shift register is cleared.
  - Reset mid-packet or mid-read abandons the transfer; no partial byte is emitted.
- Ready outputs: crypt_ready = OR of px_crypt_ready; init_ready = OR of px_init_ready. Both are registered, 1-cycle latency, and forced to 0 while the input FSM is not in IDLE.
- Write pipeline: px_din and px_ctrl are din and ctrl registered by one cycle. px_wr_en[i] is wr_en registered and ANDed with target_mask[i]. Total latency upstream to proxy: 1 cycle.
- Input FSM, IDLE:
  - wr_en with `CTRL_DATA_START: target_mask = one-hot of the first proxy with px_crypt_ready set, searching from wr_ptr upward and wrapping. wr_ptr then becomes that index+1, mod NUM_PROXIES. Go to BODY.
  - wr_en with `CTRL_INIT_START: target_mask = px_init_ready; go to BODY.
  - Either case with a zero mask: set err_no_target, go to DROP.
  - The mask must be applied to the START byte itself, i.e. computed combinationally on that cycle.
- Input FSM, BODY: forward bytes to the proxies in target_mask. wr_en with `CTRL_END forwards that byte and goes to FLUSH.
- Input FSM, FLUSH: one cycle; target_mask cleared; go to IDLE. A START arriving in FLUSH is not accepted; upstream must observe crypt_ready/init_ready first.
- Input FSM, DROP: discard bytes until `CTRL_END, then go to IDLE.
- A START arriving in BODY is treated as a body byte.
- Output FSM, SCAN: examine px_empty[rd_ptr].
  - Not empty: latch cur = rd_ptr, pulse px_rd_en[cur] for exactly 1 cycle, go to WAIT.
  - Empty: advance rd_ptr by 1 per cycle, wrapping NUM_PROXIES-1 -> 0.
- Output FSM, WAIT: count RD_LATENCY-1 cycles, then go to SHIFT.
- Output FSM, SHIFT: sample px_dout[cur] for RESULT_BITS consecutive cycles into a RESULT_BITS shift register, MSB-first. Then go to EMIT with byte_cnt = 0; rd_ptr = cur+1 (wrapped).
- Output FSM, EMIT:
  - out_valid = 1; out_data = byte byte_cnt (most-significant byte first); out_proxy = cur.
  - On out_valid & out_ready, advance byte_cnt. After the last byte (RESULT_BITS/8), out_valid drops the next cycle; go to SCAN.
  - out_data and out_proxy are held stable while out_valid & !out_ready.
- Concurrency: the input and output FSMs are independent and run concurrently.

Test Plan:
- NUM_PROXIES=4, px_crypt_ready=4'b1010, wr_ptr=0. Send DATA_START, 3 body bytes, END → px_wr_en[1] high for exactly 5 cycles, 1 cycle after each upstream byte; next packet goes to proxy 3, the one after to proxy 1.
- px_init_ready=4'b0111, INIT_START packet of 6 bytes → px_wr_en asserts 4'b0111 for 6 cycles; px_din matches input delayed by 1.
- px_crypt_ready=0, DATA_START + 2 bytes + END → no px_wr_en activity; err_no_target=1 and stays 1 until rst.
- Proxy 2 empty=0 with result 0x0123456789ABCDEF, RESULT_BITS=64, RD_LATENCY=3 → single px_rd_en[2] pulse; bytes 01,23,…,EF emitted with out_proxy=2. With out_ready toggling 1/0, each byte is held while stalled.
- Proxies 0 and 3 both non-empty → proxy 0 read first, then proxy 3; rd_ptr wraps correctly.
- rst asserted mid-SHIFT and mid-BODY → next cycle all px_wr_en/px_rd_en are 0 and out_valid=0; the next fresh packet goes to the first ready proxy from index 0.
